// File: rtl/piso_frame_tx_pkg.sv
// Shared definitions for the parallel-in serial-out frame transmitter.
//   - state_e : transmitter state machine encoding
//   - cnt_w() : width of the bit-position counter for a given frame length
package piso_frame_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits needed to count 0 .. width-1. Never returns 0, so that
    // counter declarations stay legal for every frame length.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_frame_tx_if.sv
// Bus between a word producer / serial consumer and piso_frame_tx.
//   pdata_in/pdata_valid/pdata_ready : parallel word valid/ready handshake
//   shift_en                         : downstream enable (0 freezes the serial side)
//   sout/sout_valid                  : serial bit and its qualifier
//   frame_start/frame_end            : first / last bit of a frame
//   busy                             : frame in flight or word held
// Modport slave is the transmitter's view; master is the surrounding logic.
interface piso_frame_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pdata_in;
    logic             pdata_valid;
    logic             pdata_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport slave (
        input  pdata_in, pdata_valid, shift_en,
        output pdata_ready, sout, sout_valid, frame_start, frame_end, busy
    );

    modport master (
        output pdata_in, pdata_valid, shift_en,
        input  pdata_ready, sout, sout_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter.
// Accepts WIDTH-bit words over a valid/ready handshake and sends each one
// a bit per clock (LSB first when LSB_FIRST=1), with frame_start/frame_end
// strobes on the first/last bit. A one-word holding buffer lets the next
// frame follow the current one with no idle cycle.
// Ports:
//   clk     : rising-edge clock
//   clear_n : asynchronous active-low reset
//   bus     : piso_frame_tx_if slave modport (handshake, serial output, strobes)
module piso_frame_tx
    import piso_frame_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           clear_n,
    piso_frame_tx_if.slave bus
);

    localparam int                CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q,  sreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   hold_q,  hold_d;
    logic               hold_full_q, hold_full_d;

    logic               xfer;
    logic [WIDTH-1:0]   sreg_shifted;

    assign xfer = bus.pdata_valid && bus.pdata_ready;

    // Move the next bit to the output end, zero-filling behind it.
    assign sreg_shifted = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);

    always_comb begin
        // NOTE: every signal gets its hold value first, so branches that do not
        // touch it cannot leave a path unassigned and infer a latch.
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            ST_IDLE: begin
                // The first word goes straight into the shifter, whatever shift_en says.
                if (xfer) begin
                    sreg_d  = bus.pdata_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bus.shift_en && cnt_q == LAST) begin
                    // Last-bit edge: chain the held word, else bypass a word
                    // offered right now, else the stream ends.
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else if (xfer) begin
                        sreg_d = bus.pdata_in;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (bus.shift_en) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                    // pdata_ready is low while the hold is full, so a transfer
                    // here can never overwrite an undrained word.
                    if (xfer) begin
                        hold_d      = bus.pdata_in;
                        hold_full_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the hold word is storage, but it is cleared on reset as well so the
    // whole datapath comes up in a known state and a discarded word cannot linger.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    // All outputs decode registers only, so they freeze with shift_en=0.
    assign bus.pdata_ready = ~hold_full_q;
    assign bus.sout        = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
    assign bus.sout_valid  = (state_q == ST_SHIFT);
    assign bus.frame_start = bus.sout_valid && (cnt_q == '0);
    assign bus.frame_end   = bus.sout_valid && (cnt_q == LAST);
    assign bus.busy        = bus.sout_valid || hold_full_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Self-checking bench for piso_frame_tx (WIDTH=4, LSB first).
// A per-cycle vector table covers single frames, hold-buffer chaining,
// last-bit bypass and shift_en freeze; a hand-written sequence covers an
// asynchronous mid-frame reset. A small capture register stands in for the
// downstream serial-in parallel-out block.
module tb_piso_frame_tx;

    localparam int W = 4;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         se;
        logic         e_sout;
        logic         e_sv;
        logic         e_fs;
        logic         e_fe;
        logic         e_rdy;
        logic         e_busy;
    } vec_t;

    logic clk;
    logic clear_n;
    logic [W-1:0] cap;

    int n_tests;
    int n_fail;

    piso_frame_tx_if #(.WIDTH(W)) bus_if ();

    piso_frame_tx #(
        .WIDTH     (W),
        .LSB_FIRST (1'b1)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream capture register: new bits enter at the MSB and move toward the LSB.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n)                                  cap <= '0;
        else if (bus_if.sout_valid && bus_if.shift_en) cap <= {bus_if.sout, cap[W-1:1]};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic v, input logic [W-1:0] d, input logic se,
                                 input logic sout, input logic sv, input logic fs,
                                 input logic fe, input logic rdy, input logic busy);
        vec_t r;
        r.v = v; r.d = d; r.se = se;
        r.e_sout = sout; r.e_sv = sv; r.e_fs = fs; r.e_fe = fe;
        r.e_rdy = rdy; r.e_busy = busy;
        return r;
    endfunction

    task automatic check_outputs(input string tag, input logic sout, input logic sv,
                                 input logic fs, input logic fe, input logic rdy,
                                 input logic busy);
        if (sv) check($sformatf("%s sout", tag), 32'(bus_if.sout), 32'(sout));
        check($sformatf("%s sout_valid", tag),  32'(bus_if.sout_valid),  32'(sv));
        check($sformatf("%s frame_start", tag), 32'(bus_if.frame_start), 32'(fs));
        check($sformatf("%s frame_end", tag),   32'(bus_if.frame_end),   32'(fe));
        check($sformatf("%s pdata_ready", tag), 32'(bus_if.pdata_ready), 32'(rdy));
        check($sformatf("%s busy", tag),        32'(bus_if.busy),        32'(busy));
    endtask

    vec_t vecs[32];
    int   sv_cnt;

    initial begin
        logic [W-1:0] e_bits;

        n_tests = 0;
        n_fail  = 0;
        sv_cnt  = 0;

        //               v  d     se | sout sv fs fe rdy busy
        // 4'b1011 single frame: bits 1,1,0,1
        vecs[0]  = row(1, 4'hB, 1,  0, 0, 0, 0, 1, 0);
        vecs[1]  = row(0, 4'h0, 1,  1, 1, 1, 0, 1, 1);
        vecs[2]  = row(0, 4'h0, 1,  1, 1, 0, 0, 1, 1);
        vecs[3]  = row(0, 4'h0, 1,  0, 1, 0, 0, 1, 1);
        vecs[4]  = row(0, 4'h0, 1,  1, 1, 0, 1, 1, 1);
        // 4'hA then 4'h5 via the hold: bits 0,1,0,1,1,0,1,0, ready low while held
        vecs[5]  = row(1, 4'hA, 1,  0, 0, 0, 0, 1, 0);
        vecs[6]  = row(0, 4'h0, 1,  0, 1, 1, 0, 1, 1);
        vecs[7]  = row(1, 4'h5, 1,  1, 1, 0, 0, 1, 1);
        vecs[8]  = row(1, 4'hF, 1,  0, 1, 0, 0, 0, 1);
        vecs[9]  = row(1, 4'hF, 1,  1, 1, 0, 1, 0, 1);
        vecs[10] = row(0, 4'h0, 1,  1, 1, 1, 0, 1, 1);
        vecs[11] = row(0, 4'h0, 1,  0, 1, 0, 0, 1, 1);
        vecs[12] = row(0, 4'h0, 1,  1, 1, 0, 0, 1, 1);
        vecs[13] = row(0, 4'h0, 1,  0, 1, 0, 1, 1, 1);
        // 4'hC then 4'h3 offered on the last-bit cycle with hold empty (bypass)
        vecs[14] = row(1, 4'hC, 1,  0, 0, 0, 0, 1, 0);
        vecs[15] = row(0, 4'h0, 1,  0, 1, 1, 0, 1, 1);
        vecs[16] = row(0, 4'h0, 1,  0, 1, 0, 0, 1, 1);
        vecs[17] = row(0, 4'h0, 1,  1, 1, 0, 0, 1, 1);
        vecs[18] = row(1, 4'h3, 1,  1, 1, 0, 1, 1, 1);
        vecs[19] = row(0, 4'h0, 1,  1, 1, 1, 0, 1, 1);
        vecs[20] = row(0, 4'h0, 1,  1, 1, 0, 0, 1, 1);
        vecs[21] = row(0, 4'h0, 1,  0, 1, 0, 0, 1, 1);
        vecs[22] = row(0, 4'h0, 1,  0, 1, 0, 1, 1, 1);
        // 4'h6 with shift_en low for 3 cycles after the first bit: bits 0,1,(1,1,1),1,0
        vecs[23] = row(1, 4'h6, 1,  0, 0, 0, 0, 1, 0);
        vecs[24] = row(0, 4'h0, 1,  0, 1, 1, 0, 1, 1);
        vecs[25] = row(0, 4'h0, 0,  1, 1, 0, 0, 1, 1);
        vecs[26] = row(0, 4'h0, 0,  1, 1, 0, 0, 1, 1);
        vecs[27] = row(0, 4'h0, 0,  1, 1, 0, 0, 1, 1);
        vecs[28] = row(0, 4'h0, 1,  1, 1, 0, 0, 1, 1);
        vecs[29] = row(0, 4'h0, 1,  1, 1, 0, 0, 1, 1);
        vecs[30] = row(0, 4'h0, 1,  0, 1, 0, 1, 1, 1);
        vecs[31] = row(0, 4'h0, 1,  0, 0, 0, 0, 1, 0);

        // Reset state
        clear_n            = 1'b0;
        bus_if.pdata_in    = '0;
        bus_if.pdata_valid = 1'b0;
        bus_if.shift_en    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset sout",        32'(bus_if.sout),        32'd0);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        clear_n = 1'b1;

        // Table: outputs checked at the negedge, then inputs for the next edge applied.
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            check_outputs($sformatf("vec%0d", i), vecs[i].e_sout, vecs[i].e_sv,
                          vecs[i].e_fs, vecs[i].e_fe, vecs[i].e_rdy, vecs[i].e_busy);
            if (i == 5) check("capture after 4'hB frame", 32'(cap), 32'hB);
            if (i >= 23) sv_cnt += int'(bus_if.sout_valid);
            bus_if.pdata_valid = vecs[i].v;
            bus_if.pdata_in    = vecs[i].d;
            bus_if.shift_en    = vecs[i].se;
            @(negedge clk);
        end
        check("frozen frame sout_valid cycles", 32'(sv_cnt), 32'd7);

        // Async reset mid-frame with a word held: 4'h9 in flight, 4'h5 held.
        bus_if.pdata_valid = 1'b1;
        bus_if.pdata_in    = 4'h9;
        bus_if.shift_en    = 1'b1;
        @(negedge clk);
        check("rst-seq frame_start", 32'(bus_if.frame_start), 32'd1);
        bus_if.pdata_in = 4'h5;
        @(negedge clk);
        check("rst-seq hold full ready", 32'(bus_if.pdata_ready), 32'd0);
        bus_if.pdata_valid = 1'b0;
        @(negedge clk);
        // Bit 2 of 4'h9 on sout now; pulse reset away from any clock edge.
        #2 clear_n = 1'b0;
        #1;
        check("async reset sout", 32'(bus_if.sout), 32'd0);
        check_outputs("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus_if.pdata_valid = 1'b1;
        bus_if.pdata_in    = 4'hF;
        @(negedge clk);
        check_outputs("held in reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 clear_n = 1'b1;
        bus_if.pdata_in = 4'hE;
        @(negedge clk);
        bus_if.pdata_valid = 1'b0;
        // Clean 4'hE frame: bits 0,1,1,1, then idle (the discarded 4'h5 never appears).
        e_bits = 4'hE;
        for (int b = 0; b < W; b++) begin
            check_outputs($sformatf("post-reset bit%0d", b), e_bits[b], 1'b1,
                          logic'(b == 0), logic'(b == W - 1), 1'b1, 1'b1);
            @(negedge clk);
        end
        check_outputs("post-reset idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post-reset capture", 32'(cap), 32'hE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
Parallel-in serial-out transmitter that feeds the team's serial-in parallel-out capture register.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Serialises each word one bit per clock, LSB first by default. This matches a capture register that shifts new bits in at the MSB and moves toward the LSB.
- A one-word holding buffer allows back-to-back frames with no idle gap.
- Frame strobes mark the first and last bit so the downstream block knows when its parallel word is complete.

Parameters:
- WIDTH, 4, data word and frame length in bits (WIDTH >= 2).
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 first.

Ports:
- clk  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- pdata_in  in  WIDTH  parallel word to transmit.
- pdata_valid  in  1  pdata_in is valid.
- pdata_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  downstream enable; 0 = freeze serial output.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout carries a frame bit.
- frame_start  out  1  sout is the first bit of a frame.
- frame_end  out  1  sout is the last bit of a frame.
- busy  out  1  frame in flight or word held.

Behaviour:
- Internal state: sreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0], hold[WIDTH-1:0], hold_full, and a state machine with states IDLE and SHIFT.
- Reset (clear_n low, asynchronous): state=IDLE, sreg=0, cnt=0, hold=0, hold_full=0.
  - Outputs under reset: sout=0, sout_valid=0, frame_start=0, frame_end=0, busy=0.
  - pdata_ready reads 1, but no transfer occurs while clear_n is low.
- Reset mid-frame: the partial frame and the held word are discarded. There is no partial-frame completion.
- Handshake:
  - Transfer occurs when pdata_valid && pdata_ready at a rising edge.
  - pdata_ready = ~hold_full (combinational from a register).
  - pdata_in is sampled only on a transfer.
- IDLE:
  - On transfer: sreg <= pdata_in, cnt <= 0, state <= SHIFT. This happens regardless of shift_en.
  - Latency: the first bit appears on sout in the cycle after the accepting edge.
- SHIFT with shift_en=1 and cnt < WIDTH-1:
  - sreg shifts toward the output end: right if LSB_FIRST, left otherwise, zero-filled.
  - cnt increments.
  - A transfer in this cycle loads hold and sets hold_full.
- SHIFT with shift_en=1 and cnt == WIDTH-1 (last-bit edge):
  - hold_full=1: sreg <= hold, hold_full <= 0, cnt <= 0, stay in SHIFT. No gap between frames.
  - else, on a transfer (bypass): sreg <= pdata_in, cnt <= 0, stay in SHIFT.
  - else: state <= IDLE.
- SHIFT with shift_en=0:
  - sreg, cnt and state hold.
  - sout, sout_valid and the strobes hold their values.
  - A transfer into hold is still allowed.
- Outputs (combinational from registers only):
  - sout = LSB_FIRST ? sreg[0] : sreg[WIDTH-1].
  - sout_valid = (state == SHIFT).
  - frame_start = sout_valid && cnt == 0.
  - frame_end = sout_valid && cnt == WIDTH-1.
  - busy = sout_valid || hold_full.
- Frame length: exactly WIDTH sout_valid cycles with shift_en=1. For WIDTH=2, frame_start and frame_end are on adjacent cycles, never coincident.
- Simultaneous events:
  - A transfer on the last-bit edge with the hold empty takes the bypass path.
  - The hold can never be written and drained on the same edge, because pdata_ready=0 whenever hold_full=1.
- Throughput: one word per WIDTH cycles sustained; cnt never exceeds WIDTH-1.

Decomposition:
- Shared package: state enum (ST_IDLE, ST_SHIFT) and a CNT_W = $clog2(WIDTH) helper function.
- Single module; no sub-module required. The hold register is small enough to stay inline.

Test Plan:
- Reset, then transfer 4'b1011 with shift_en=1 -> sout = 1,1,0,1 over 4 cycles; frame_start on cycle 1, frame_end on cycle 4; sout_valid drops on cycle 5.
- Same stream into the SIPO capture register -> its dout = 4'b1011 on the edge after frame_end.
- Transfer 4'hA, then 4'h5 two cycles later -> pdata_ready=0 until the 4'hA frame ends; bits 0,1,0,1,1,0,1,0 with no gap; two frame_end pulses 4 cycles apart.
- Bypass: transfer 4'h3 exactly on the last-bit cycle of 4'hC with the hold empty -> 4'h3 frame starts the next cycle with no gap.
- shift_en=0 for 3 cycles mid-frame of 4'h6 -> sout and cnt frozen; frame resumes with the correct remaining bits; total sout_valid = 7 cycles.
- clear_n pulsed low asynchronously (mid-cycle) during bit 2 with hold_full=1 -> outputs 0 immediately, busy=0, pdata_ready=1; the next transfer starts a clean frame.
